// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-side sequencing controller driving the PC
module fetch_ctrl #(
  parameter int          CNT_W   = 16,
  parameter logic [9:0]  MAX_PC  = 10'd63,
  parameter logic [8:0]  HALT_OP = 9'h1FF
) (
  input  logic             CLK,
  input  logic             init_n,
  input  logic             start_i,
  input  logic [8:0]       inst_i,
  input  logic [9:0]       pc_i,
  input  logic             pc_halt_i,
  input  logic             flag_we_i,
  input  logic             flag_d_i,
  output logic             pc_init,
  output logic             jump_en,
  output logic             branch_en,
  output logic [6:0]       counter,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic               flag, flag_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  logic is_halt, is_jmp, is_brc, end_run;

  // Instruction classes; HALT_OP also matches the JMP prefix so it is excluded there.
  assign is_halt = (inst_i == HALT_OP);
  assign is_jmp  = (inst_i[8:7] == 2'b11) && !is_halt;
  assign is_brc  = (inst_i[8:4] == 5'b10110);
  // PC-side termination: halt flag from the PC or PC walked past the program.
  assign end_run = pc_halt_i || (pc_i > MAX_PC);

  assign instr_count = cnt;

  // State, condition flag and executed-instruction counter registers.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state <= IDLE;
      flag  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      flag  <= flag_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and PC control decode; requests only issue in RUN with no pending stop.
  always_comb begin
    state_nx  = state;
    flag_nx   = flag;
    cnt_nx    = cnt;
    pc_init   = 1'b1;
    jump_en   = 1'b0;
    branch_en = 1'b0;
    counter   = 7'd0;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = RUN;
          flag_nx  = 1'b0;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        pc_init = 1'b0;
        busy    = 1'b1;
        if (cnt != '1) begin
          cnt_nx = cnt + CNT_W'(1);
        end
        if (flag_we_i) begin
          flag_nx = flag_d_i;
        end
        if (end_run || is_halt) begin
          state_nx = DONE;
        end else begin
          jump_en   = is_jmp;
          // Branch sees the registered flag, not a same-cycle write.
          branch_en = is_brc && flag;
          counter   = is_jmp ? inst_i[6:0] : 7'd0;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start_i) begin
          state_nx = RUN;
          flag_nx  = 1'b0;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          init_n;
  logic          start_i;
  logic [8:0]    inst_i;
  logic [9:0]    pc_i;
  logic          pc_halt_i;
  logic          flag_we_i;
  logic          flag_d_i;
  logic          pc_init;
  logic          jump_en;
  logic          branch_en;
  logic [6:0]    counter;
  logic          done;
  logic          busy;
  logic [CW-1:0] instr_count;

  int total = 0;
  int bad   = 0;

  // reference model: running / finished flags, condition flag, count
  bit m_run;
  bit m_fin;
  bit m_flag;
  int m_cnt;

  fetch_ctrl #(.CNT_W(CW)) dut (
    .CLK         (CLK),
    .init_n      (init_n),
    .start_i     (start_i),
    .inst_i      (inst_i),
    .pc_i        (pc_i),
    .pc_halt_i   (pc_halt_i),
    .flag_we_i   (flag_we_i),
    .flag_d_i    (flag_d_i),
    .pc_init     (pc_init),
    .jump_en     (jump_en),
    .branch_en   (branch_en),
    .counter     (counter),
    .done        (done),
    .busy        (busy),
    .instr_count (instr_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_fin  = 1'b0;
    m_flag = 1'b0;
    m_cnt  = 0;
  endtask

  // Drive one cycle of inputs and compare every output with the model.
  task automatic drive(input bit st, input logic [8:0] in, input logic [9:0] pc,
                       input bit ph, input bit we, input bit d);
    bit stop, halt, jmp, brc, live;
    start_i   = st;
    inst_i    = in;
    pc_i      = pc;
    pc_halt_i = ph;
    flag_we_i = we;
    flag_d_i  = d;
    #2;
    stop = ph || (pc > 10'd63);
    halt = (in == 9'h1FF);
    jmp  = (in[8:7] == 2'b11) && !halt;
    brc  = (in[8:4] == 5'b10110);
    live = m_run && !stop && !halt;
    chk("pc_init",     pc_init,     !m_run);
    chk("jump_en",     jump_en,     live && jmp);
    chk("branch_en",   branch_en,   live && brc && m_flag);
    chk("counter",     counter,     (live && jmp) ? in[6:0] : 7'd0);
    chk("done",        done,        m_fin);
    chk("busy",        busy,        m_run);
    chk("instr_count", instr_count, m_cnt);
  endtask

  // Clock edge: advance the model with the inputs still applied.
  task automatic advance();
    @(posedge CLK);
    if (m_run) begin
      m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
      if (flag_we_i) m_flag = flag_d_i;
      if (pc_halt_i || pc_i > 10'd63 || inst_i == 9'h1FF) begin
        m_run = 1'b0;
        m_fin = 1'b1;
      end
    end else if (start_i) begin
      m_run  = 1'b1;
      m_fin  = 1'b0;
      m_flag = 1'b0;
      m_cnt  = 0;
    end
    @(negedge CLK);
  endtask

  task automatic step(input bit st, input logic [8:0] in, input logic [9:0] pc,
                      input bit ph, input bit we, input bit d);
    drive(st, in, pc, ph, we, d);
    advance();
  endtask

  initial begin
    logic [8:0] ri;
    logic [9:0] rp;
    int r;
    init_n = 1'b0;
    start_i = 0; inst_i = 0; pc_i = 0; pc_halt_i = 0; flag_we_i = 0; flag_d_i = 0;
    model_reset();

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #2;
      chk("rst_pc_init", pc_init, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cnt", instr_count, 0);
    end
    init_n = 1'b1;
    @(negedge CLK);

    // idle, start, plain instructions
    step(0, 9'h000, 10'd0, 0, 0, 0);
    step(1, 9'h000, 10'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 9'h000, 10'd1, 0, 0, 0);
    chk("cnt_after3", instr_count, 3);

    // forward and backward jumps
    drive(0, 9'h185, 10'd4, 0, 0, 0);
    chk("jmp_fwd_off", counter, 7'h05);
    advance();
    drive(0, 9'h1FE, 10'd9, 0, 0, 0);
    chk("jmp_back_off", counter, 7'h7E);
    chk("jmp_back_brc", branch_en, 1'b0);
    advance();

    // branch on registered flag, no bypass
    drive(0, 9'h160, 10'd7, 0, 1, 1);
    chk("brc_old_flag", branch_en, 1'b0);
    advance();
    drive(0, 9'h160, 10'd8, 0, 0, 0);
    chk("brc_flag_set", branch_en, 1'b1);
    advance();
    step(0, 9'h000, 10'd10, 0, 1, 0);
    step(0, 9'h160, 10'd11, 0, 0, 0);

    // halt opcode, frozen count, restart clears
    step(0, 9'h1FF, 10'd12, 0, 0, 0);
    drive(0, 9'h000, 10'd0, 0, 1, 1);
    chk("halt_done", done, 1'b1);
    advance();
    step(0, 9'h000, 10'd0, 0, 0, 0);
    step(1, 9'h000, 10'd0, 0, 0, 0);
    step(0, 9'h160, 10'd0, 0, 0, 0);

    // PC limit and PC halt flag
    step(0, 9'h185, 10'd64, 0, 0, 0);
    step(0, 9'h000, 10'd0, 0, 0, 0);
    step(1, 9'h000, 10'd0, 0, 0, 0);
    step(0, 9'h185, 10'd10, 1, 0, 0);
    drive(0, 9'h000, 10'd0, 0, 0, 0);
    chk("pchalt_done", done, 1'b1);
    advance();

    // counter saturation
    step(1, 9'h000, 10'd0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 9'h000, 10'd3, 0, 0, 0);
    chk("cnt_sat", instr_count, (1 << CW) - 1);

    // asynchronous reset during a jump cycle
    drive(0, 9'h185, 10'd5, 0, 0, 0);
    chk("ar_jump_before", jump_en, 1'b1);
    init_n = 1'b0;
    #1;
    chk("ar_jump", jump_en, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_pc_init", pc_init, 1'b1);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    init_n = 1'b1;
    step(0, 9'h185, 10'd5, 0, 0, 0);
    step(0, 9'h185, 10'd5, 0, 0, 0);
    step(1, 9'h000, 10'd0, 0, 0, 0);

    // randomized phase
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      ri = 9'h1FF;
      else if (r < 6)  ri = {2'b11, 7'($urandom)};
      else if (r < 10) ri = {5'b10110, 4'($urandom)};
      else             ri = 9'($urandom);
      rp = ($urandom_range(0, 15) == 0) ? 10'(64 + $urandom_range(0, 959)) : 10'($urandom_range(0, 63));
      step($urandom_range(0, 7) == 0, ri, rp, $urandom_range(0, 31) == 0,
           1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller on the instruction side of the program counter.
- Each cycle, inspects the instruction at the current PC (combinational instruction memory) and drives the PC's init, jump_en, branch_en and 7-bit counter inputs.
- Holds the condition flag, the run/halt state machine and an executed-instruction counter.
- Sits between instruction memory, ALU flag output and the PC.

Parameters:
- CNT_W, 16, width of executed-instruction counter.
- MAX_PC, 10'd63, last legal PC; any pc_i above it ends the run.
- HALT_OP, 9'h1FF, instruction encoding that ends the run.

Ports:
- CLK  input  1  clock, rising edge.
- init_n  input  1  asynchronous active-low reset.
- start_i  input  1  begin/restart program execution.
- inst_i  input  9  instruction at current PC, valid same cycle.
- pc_i  input  10  current PC value.
- pc_halt_i  input  1  halt flag from PC.
- flag_we_i  input  1  ALU compare result write enable.
- flag_d_i  input  1  ALU compare result.
- pc_init  output  1  synchronous init to PC (high = PC held at 0).
- jump_en  output  1  relative jump request to PC.
- branch_en  output  1  skip-next (PC+2) request to PC.
- counter  output  7  jump offset, 7-bit two's complement.
- done  output  1  program finished.
- busy  output  1  state == RUN.
- instr_count  output  CNT_W  instructions executed this run.

Behaviour:
- States: IDLE, RUN, DONE. 2-bit state register and flag register both reset asynchronously on init_n low.
- Reset values: state=IDLE, flag=0, instr_count=0.
- Reset outputs: pc_init=1, jump_en=0, branch_en=0, counter=0, done=0, busy=0.
- IDLE:
  - pc_init=1, all requests 0.
  - start_i=1 -> RUN next edge; flag and instr_count cleared on that edge.
- RUN:
  - pc_init=0, busy=1.
  - Decode is combinational from inst_i, gated by state==RUN, priority HALT > JMP > BRC > other.
  - HALT: inst_i==HALT_OP. No jump/branch request; next state DONE.
  - JMP: inst_i[8:7]==2'b11 and not HALT_OP. jump_en=1, counter=inst_i[6:0]. Offset is signed: 7'h7F = -1, 7'h40 = -64, 7'h3F = +63.
  - BRC: inst_i[8:4]==5'b10110. branch_en=1 only if registered flag==1. Uses the flag value before any same-cycle flag write (no bypass).
  - Other instructions: no request; PC increments.
  - counter=0 whenever jump_en=0.
  - flag_we_i=1 -> flag<=flag_d_i at the edge, in any decoded instruction class.
  - instr_count increments every RUN cycle and saturates at all-ones.
  - pc_halt_i=1 or pc_i>MAX_PC -> DONE next edge. Outputs that cycle are all 0 (the request is suppressed).
  - start_i ignored while in RUN.
- DONE:
  - done=1, pc_init=1 (freezes PC at 0 and clears its halt), requests 0.
  - flag and instr_count hold.
  - start_i=1 -> RUN; flag and instr_count cleared, done drops next cycle.
- jump_en and branch_en are never high in the same cycle.
- init_n low at any time: immediate return to reset values, regardless of state or pending requests.
- flag_we_i outside RUN is ignored.

Test Plan:
- Reset then start: init_n low 3 cycles, release, start_i pulse -> pc_init 1 until the edge after start, busy=1 next cycle. Instruction 9'h000 -> no requests; instr_count 1,2,3 on successive cycles.
- Forward/backward jump: inst_i=9'h185 -> jump_en=1, counter=7'h05. inst_i=9'h1FE -> jump_en=1, counter=7'h7E (-2). branch_en=0 in both cases.
- Branch on flag:
  - flag_we_i=1, flag_d_i=1 with inst_i=9'h160 (BRC) -> branch_en=0 that cycle (old flag=0).
  - Next cycle BRC -> branch_en=1.
  - Write flag_d_i=0, then BRC -> branch_en=0.
- Halt opcode: inst_i=9'h1FF in RUN -> jump_en=0. Next cycle done=1, pc_init=1, busy=0, instr_count frozen. start_i -> RUN with instr_count=0, flag=0.
- PC limit: pc_i=10'd64 with inst_i=9'h185 -> jump_en=0, DONE next edge. pc_halt_i=1 with pc_i=10 -> DONE next edge.
- Async reset mid-run: init_n asserted between clock edges during a JMP cycle -> jump_en, busy drop to 0 and pc_init rises to 1 immediately. State returns to IDLE; start_i required to resume.
